// File: rtl/alarm_clock.sv
// 24-hour HH:MM:SS clock with a button-driven time-set mode and 7-segment decodes.
// Buttons are synchronised and debounced here because the block sits directly on board pins.

module debounceButton #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic          levelPrev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        sync <= {sync[0], raw};
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt       <= '0;
            level     <= 1'b0;
            levelPrev <= 1'b0;
        end else begin
            levelPrev <= level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~levelPrev;
endmodule

module alarm_clock #(
    parameter int TICKS_PER_SEC   = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       set_time,
    input  logic       switch_select_in,
    input  logic       increment_in,
    output logic [3:0] secU,
    output logic [3:0] secT,
    output logic [3:0] minU,
    output logic [3:0] minT,
    output logic [3:0] hrU,
    output logic [3:0] hrT,
    output logic [6:0] secUSeg,
    output logic [6:0] secTSeg,
    output logic [6:0] minUSeg,
    output logic [6:0] minTSeg,
    output logic [6:0] hrUSeg,
    output logic [6:0] hrTSeg
);
    localparam int PW = $clog2(TICKS_PER_SEC + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [2:0] {
        P_SECU, P_SECT, P_MINU, P_MINT, P_HRU, P_HRT
    } digitSel_e;

    logic [1:0]    setSync;
    logic          setMode;
    logic [1:0]    btnRaw;
    logic [1:0]    btnPress;
    logic          selPress;
    logic          incPress;
    logic [PW-1:0] presc;
    logic          tick;
    digitSel_e     ptr;
    digitSel_e     ptrNext;
    logic [3:0]    nSecU, nSecT, nMinU, nMinT, nHrU, nHrT;

    always_ff @(posedge clk) begin
        setSync <= {setSync[0], set_time};
    end
    assign setMode = setSync[1];

    assign btnRaw = {increment_in, switch_select_in};

    debounceButton #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDeb [1:0] (
        .clk   (clk),
        .resetn(resetn),
        .raw   (btnRaw),
        .press (btnPress)
    );
    assign selPress = btnPress[0];
    assign incPress = btnPress[1];

    assign tick = !setMode && (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!resetn || setMode || tick) presc <= '0;
        else                            presc <= presc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) ptr <= P_SECU;
        else         ptr <= ptrNext;
    end

    always_comb begin
        ptrNext = ptr;
        if (!setMode) begin
            ptrNext = P_SECU;
        end else if (selPress) begin
            case (ptr)
                P_SECU:  ptrNext = P_SECT;
                P_SECT:  ptrNext = P_MINU;
                P_MINU:  ptrNext = P_MINT;
                P_MINT:  ptrNext = P_HRU;
                P_HRU:   ptrNext = P_HRT;
                default: ptrNext = P_SECU;
            endcase
        end
    end

    always_comb begin
        nSecU = secU;
        nSecT = secT;
        nMinU = minU;
        nMinT = minT;
        nHrU  = hrU;
        nHrT  = hrT;
        if (tick) begin
            if (secU != 4'd9) nSecU = secU + 4'd1;
            else begin
                nSecU = 4'd0;
                if (secT != 4'd5) nSecT = secT + 4'd1;
                else begin
                    nSecT = 4'd0;
                    if (minU != 4'd9) nMinU = minU + 4'd1;
                    else begin
                        nMinU = 4'd0;
                        if (minT != 4'd5) nMinT = minT + 4'd1;
                        else begin
                            nMinT = 4'd0;
                            if (hrT == 4'd2 && hrU == 4'd3) begin
                                nHrT = 4'd0;
                                nHrU = 4'd0;
                            end else if (hrU == 4'd9) begin
                                nHrU = 4'd0;
                                nHrT = hrT + 4'd1;
                            end else begin
                                nHrU = hrU + 4'd1;
                            end
                        end
                    end
                end
            end
        end else if (setMode && incPress) begin
            // Set-mode increments touch one digit only; no carries.
            case (ptr)
                P_SECU: nSecU = (secU >= 4'd9) ? 4'd0 : secU + 4'd1;
                P_SECT: nSecT = (secT >= 4'd5) ? 4'd0 : secT + 4'd1;
                P_MINU: nMinU = (minU >= 4'd9) ? 4'd0 : minU + 4'd1;
                P_MINT: nMinT = (minT >= 4'd5) ? 4'd0 : minT + 4'd1;
                P_HRU:  nHrU  = (hrU >= ((hrT == 4'd2) ? 4'd3 : 4'd9)) ? 4'd0 : hrU + 4'd1;
                P_HRT: begin
                    if (hrT >= 4'd2) nHrT = 4'd0;
                    else begin
                        nHrT = hrT + 4'd1;
                        // Landing on 2x must not leave an illegal 24..29.
                        if (hrT == 4'd1 && hrU > 4'd3) nHrU = 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            secU <= 4'd0;
            secT <= 4'd0;
            minU <= 4'd0;
            minT <= 4'd0;
            hrU  <= 4'd0;
            hrT  <= 4'd0;
        end else begin
            secU <= nSecU;
            secT <= nSecT;
            minU <= nMinU;
            minT <= nMinT;
            hrU  <= nHrU;
            hrT  <= nHrT;
        end
    end

    // Active-low segments, bit0 = a ... bit6 = g.
    function automatic logic [6:0] segDecode(input logic [3:0] d);
        case (d)
            4'd0:    segDecode = 7'b1000000;
            4'd1:    segDecode = 7'b1111001;
            4'd2:    segDecode = 7'b0100100;
            4'd3:    segDecode = 7'b0110000;
            4'd4:    segDecode = 7'b0011001;
            4'd5:    segDecode = 7'b0010010;
            4'd6:    segDecode = 7'b0000010;
            4'd7:    segDecode = 7'b1111000;
            4'd8:    segDecode = 7'b0000000;
            4'd9:    segDecode = 7'b0010000;
            default: segDecode = 7'b1111111;
        endcase
    endfunction

    assign secUSeg = segDecode(secU);
    assign secTSeg = segDecode(secT);
    assign minUSeg = segDecode(minU);
    assign minTSeg = segDecode(minT);
    assign hrUSeg  = segDecode(hrU);
    assign hrTSeg  = segDecode(hrT);
endmodule

// File: tb/tb_alarm_clock.sv
// Directed bench for alarm_clock: one tick per clock, default debounce length.

module tb_alarm_clock;
    logic       clk = 1'b0;
    logic       resetn;
    logic       setTime;
    logic       selIn;
    logic       incIn;
    logic [3:0] secU, secT, minU, minT, hrU, hrT;
    logic [6:0] secUSeg, secTSeg, minUSeg, minTSeg, hrUSeg, hrTSeg;
    logic [23:0] tm;
    int tests = 0;
    int fails = 0;

    alarm_clock #(.TICKS_PER_SEC(1), .DEBOUNCE_CYCLES(8)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .set_time        (setTime),
        .switch_select_in(selIn),
        .increment_in    (incIn),
        .secU            (secU),
        .secT            (secT),
        .minU            (minU),
        .minT            (minT),
        .hrU             (hrU),
        .hrT             (hrT),
        .secUSeg         (secUSeg),
        .secTSeg         (secTSeg),
        .minUSeg         (minUSeg),
        .minTSeg         (minTSeg),
        .hrUSeg          (hrUSeg),
        .hrTSeg          (hrTSeg)
    );

    always #5 clk = ~clk;

    assign tm = {hrT, hrU, minT, minU, secT, secU};

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold buttons 12 cycles, then release 12 cycles so the debounced level drops again.
    task automatic press(input logic doSel, input logic doInc);
        selIn = doSel;
        incIn = doInc;
        repeat (12) @(posedge clk);
        @(negedge clk);
        selIn = 1'b0;
        incIn = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        resetn  = 1'b0;
        setTime = 1'b0;
        selIn   = 1'b0;
        incIn   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        chk("reset_time", 48'(tm), 48'h000000);
        chk("reset_segs", {6'd0, secUSeg, secTSeg, minUSeg, minTSeg, hrUSeg, hrTSeg},
            {6'd0, {6{7'b1000000}}});

        @(posedge clk); @(negedge clk);
        chk("first_tick", 48'(tm), 48'h000001);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("ten_ticks", 48'(tm), 48'h000010);
        chk("ten_ticks_seg", {34'd0, secTSeg, secUSeg}, {34'd0, 7'b1111001, 7'b1000000});

        // Reset mid-count with set_time held so the clock comes up frozen.
        setTime = 1'b1;
        resetn  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        chk("reset_into_set", 48'(tm), 48'h000000);

        selIn = 1'b1;
        incIn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        selIn = 1'b0;
        incIn = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("glitch_ignored", 48'(tm), 48'h000000);

        press(1'b0, 1'b1);
        chk("ptr_still_secU", 48'(tm), 48'h000001);
        for (int i = 2; i <= 10; i++) begin
            press(1'b0, 1'b1);
            chk("secU_inc", 48'(tm), 48'(i % 10));
        end

        press(1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            press(1'b0, 1'b1);
            chk("secT_inc", 48'(tm), 48'((i % 6) << 4));
        end

        repeat (3) press(1'b1, 1'b0);
        repeat (9) press(1'b0, 1'b1);
        chk("hrU_to_9", 48'(tm), 48'h090000);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        chk("hrT_1", 48'(tm), 48'h190000);
        press(1'b0, 1'b1);
        chk("hrT_2_forces_hrU", 48'(tm), 48'h200000);
        press(1'b0, 1'b1);
        chk("hrT_wrap", 48'(tm), 48'h000000);

        // Preset 23:59:59.
        repeat (2) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (9) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (5) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (9) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (5) press(1'b0, 1'b1);
        chk("preset_min_sec", 48'(tm), 48'h205959);
        press(1'b1, 1'b0);
        repeat (4) press(1'b0, 1'b1);
        chk("hrU_wrap_at_3", 48'(tm), 48'h205959);
        repeat (3) press(1'b0, 1'b1);
        chk("preset_235959", 48'(tm), 48'h235959);
        chk("preset_segs", {6'd0, hrTSeg, hrUSeg, minTSeg, minUSeg, secTSeg, secUSeg},
            {6'd0, 7'b0100100, 7'b0110000, 7'b0010010, 7'b0010000, 7'b0010010, 7'b0010000});

        // set_time reaches the core two edges later; the third edge ticks.
        setTime = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sync_latency", 48'(tm), 48'h235959);
        @(posedge clk); @(negedge clk);
        chk("rollover", 48'(tm), 48'h000000);

        setTime = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("enter_set", 48'(tm), 48'h000002);
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("freeze_50", 48'(tm), 48'h000002);

        press(1'b0, 1'b1);
        chk("ptr_back_secU", 48'(tm), 48'h000003);
        press(1'b1, 1'b1);
        chk("sel_inc_same", 48'(tm), 48'h000004);
        press(1'b0, 1'b1);
        chk("ptr_advanced", 48'(tm), 48'h000014);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
